// File: rtl/motor_pkg.sv
// Shared types and constants for the Motor-A L298 command sequencer.
// Holds the FSM state encoding, direction constants, duty levels and the ramp-step helper.
package motor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DECEL = 2'd2,
        DEAD  = 2'd3
    } motor_state_t;

    localparam logic FWD = 1'b0;
    localparam logic REV = 1'b1;

    localparam logic [7:0] DUTY_100 = 8'd100;
    localparam logic [7:0] DUTY_75  = 8'd75;
    localparam logic [7:0] DUTY_50  = 8'd50;
    localparam logic [7:0] DUTY_25  = 8'd25;
    localparam logic [7:0] DUTY_MAX = 8'd100;

    // One ramp step toward goal; lands exactly on goal instead of overshooting.
    function automatic logic [7:0] ramp_toward(input logic [7:0] cur,
                                               input logic [7:0] goal,
                                               input logic [7:0] step);
        logic [7:0] res;
        res = cur;
        if (cur < goal) begin
            res = ((goal - cur) > step) ? cur + step : goal;
        end else if (cur > goal) begin
            res = ((cur - goal) > step) ? cur - step : goal;
        end
        if (res > DUTY_MAX) begin
            res = DUTY_MAX;
        end
        return res;
    endfunction

endpackage

// File: rtl/motor_tick_div.sv
// Free-running prescaler: counts 0..DIV-1 and pulses tick for one clock on the wrap.
module motor_tick_div #(
    parameter int DIV = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/motor_dir_sequencer.sv
// Motor-A direction/duty sequencer: switch decode, duty ramping and safe reversal with dead time.
// Define MOTOR_BRAKE_EN to fast-brake (in1=in2=1) during dead time instead of coasting.
module motor_dir_sequencer
    import motor_pkg::*;
#(
    parameter int RAMP_DIV    = 1_000_000,
    parameter int RAMP_STEP   = 1,
    parameter int DEAD_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sw,
    output logic [7:0] duty,
    output logic       in1,
    output logic       in2,
    output logic       busy
);

    localparam int         DW   = $clog2(DEAD_CYCLES + 1);
    localparam logic [7:0] STEP = 8'(RAMP_STEP);

    logic [7:0]   sw_meta;
    logic [7:0]   sw_sync;
    logic         cmd_dir;
    logic [7:0]   target;
    logic         tick;
    motor_state_t state;
    motor_state_t state_next;
    logic         dir_cur;
    logic         dir_next;
    logic [DW-1:0] dead_cnt;
    logic [DW-1:0] dead_next;
    logic [7:0]   goal;
    logic [7:0]   duty_next;

    motor_tick_div #(.DIV(RAMP_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    // Lowest set switch index wins; no switch means stop.
    always_comb begin
        cmd_dir = FWD;
        target  = '0;
        if      (sw_sync[0]) begin cmd_dir = FWD; target = DUTY_100; end
        else if (sw_sync[1]) begin cmd_dir = FWD; target = DUTY_75;  end
        else if (sw_sync[2]) begin cmd_dir = FWD; target = DUTY_50;  end
        else if (sw_sync[3]) begin cmd_dir = FWD; target = DUTY_25;  end
        else if (sw_sync[4]) begin cmd_dir = REV; target = DUTY_100; end
        else if (sw_sync[5]) begin cmd_dir = REV; target = DUTY_75;  end
        else if (sw_sync[6]) begin cmd_dir = REV; target = DUTY_50;  end
        else if (sw_sync[7]) begin cmd_dir = REV; target = DUTY_25;  end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            dir_cur  <= FWD;
            dead_cnt <= '0;
            duty     <= '0;
        end else begin
            state    <= state_next;
            dir_cur  <= dir_next;
            dead_cnt <= dead_next;
            duty     <= duty_next;
        end
    end

    always_comb begin
        state_next = state;
        dir_next   = dir_cur;
        dead_next  = dead_cnt;
        goal       = '0;
        duty_next  = duty;
        in1        = 1'b0;
        in2        = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                duty_next = '0;
                if (target != '0) begin
                    dir_next   = cmd_dir;
                    state_next = RUN;
                end
            end
            RUN: begin
                goal = target;
                in1  = (dir_cur == FWD);
                in2  = (dir_cur == REV);
                if (target != '0 && cmd_dir != dir_cur) begin
                    state_next = DECEL;
                end else if (target == '0 && duty == '0) begin
                    state_next = IDLE;
                end
                if (tick) begin
                    duty_next = ramp_toward(duty, goal, STEP);
                end
            end
            DECEL: begin
                in1  = (dir_cur == FWD);
                in2  = (dir_cur == REV);
                busy = 1'b1;
                if (cmd_dir == dir_cur && target != '0) begin
                    state_next = RUN;
                end else if (duty == '0) begin
                    state_next = DEAD;
                    dead_next  = DW'(DEAD_CYCLES - 1);
                end
                if (tick) begin
                    duty_next = ramp_toward(duty, goal, STEP);
                end
            end
            DEAD: begin
                busy      = 1'b1;
                duty_next = '0;
`ifdef MOTOR_BRAKE_EN
                in1 = 1'b1;
                in2 = 1'b1;
`else
                in1 = 1'b0;
                in2 = 1'b0;
`endif
                // The count is never reloaded here, so command changes cannot extend it.
                if (dead_cnt == '0) begin
                    if (target == '0) begin
                        state_next = IDLE;
                    end else begin
                        dir_next   = cmd_dir;
                        state_next = RUN;
                    end
                end else begin
                    dead_next = dead_cnt - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
